decode_ctrl: RTL and testbench
==============================

// Module: decode_ctrl
// PURPOSE
//  Registered decode stage between fetch (IF) and execute (EX).
//  Decodes each accepted instruction into the immediate-select code for imm_gen and the EX/MEM/WB control bits.
//  Holds the result behind a valid/ready handshake and inserts one bubble on a load-use hazard.
//  Honours pipeline flush and counts inserted bubbles.
// PARAMETERS
//  XLEN   32  instruction/PC width
//  CNT_W  16  width of bubble counter
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  reset        in   1      synchronous, active-high
//  flush        in   1      kill the held decode and any incoming instr (branch redirect)
//  if_valid     in   1      IF presents an instruction
//  if_ready     out  1      decode accepts the IF instruction this cycle
//  if_instr     in   XLEN   raw instruction
//  if_pc        in   XLEN   PC of if_instr
//  id_valid     out  1      decoded bundle valid toward EX
//  ex_ready     in   1      EX consumes the bundle this cycle
//  id_pc        out  XLEN   registered PC
//  id_imm_bits  out  25     registered instr[31:7]; drives imm_gen.instr
//  id_immsel    out  4      0=R/none,1=I,2=S,3=B,4=U,5=J,6=I-shamt
//  id_rs1/id_rs2/id_rd out 5 register fields, instr[19:15]/[24:20]/[11:7]
//  id_funct3    out  3      instr[14:12]
//  id_regwen    out  1      writes rd (forced 0 when rd==0)
//  id_memread   out  1      load
//  id_memwrite  out  1      store
//  id_alusrc    out  1      ALU operand B = immediate
//  id_branch    out  1      conditional branch
//  id_jump      out  1      JAL/JALR
//  id_wbsel     out  2      0=ALU,1=MEM,2=PC+4
//  id_illegal   out  1      unrecognised opcode
//  bubble_cnt   out  CNT_W  load-use bubbles inserted; saturates at all-ones
// BEHAVIOUR
//  Reset: id_valid=0, all id_* registers 0, bubble_cnt=0, if_ready=0 during reset.
//  Decode (opcode=instr[6:0]):
//   0110111 LUI / 0010111 AUIPC: U, regwen, alusrc.
//   1101111 JAL: J, jump, wbsel=2, regwen.
//   1100111 JALR: I, jump, alusrc, wbsel=2, regwen.
//   1100011 BRANCH: B, branch.
//   0000011 LOAD: I, memread, alusrc, wbsel=1, regwen.
//   0100011 STORE: S, memwrite, alusrc.
//   0010011 OP-IMM: I; funct3 001/101 -> 6; alusrc, regwen.
//   0110011 OP: immsel=0, regwen.
//   Other opcodes: immsel=0, all enables 0, illegal=1.
//  uses_rs1: all opcodes except LUI/AUIPC/JAL.
//  uses_rs2: BRANCH, STORE, OP.
//  hazard = if_valid & id_valid & id_memread & id_rd!=0 &
//           ((uses_rs1 & rs1==id_rd) | (uses_rs2 & rs2==id_rd))
//  if_ready = ~reset & ~flush & ~hazard & (~id_valid | ex_ready); combinational.
//  Accept (if_valid & if_ready): decoded bundle registered next edge, id_valid<=1; latency 1 cycle.
//  Hold: id_valid & ~ex_ready -> all id_* stable; no new accept.
//  Drain: ex_ready & id_valid & no accept -> id_valid<=0.
//  Hazard: EX takes the load and id_valid<=0 (one bubble); bubble_cnt+=1 only if ex_ready that cycle.
//   The following cycle hazard is false and the instr is accepted. Exactly one bubble per load-use pair.
//  Flush: id_valid<=0 next edge; incoming instr not accepted; bubble_cnt unchanged. Priority: reset > flush > accept.
//  id_valid=0: id_* payload is don't-care but must not change enable outputs toward EX.
//  Back-to-back accepts give one bundle per cycle with no gaps.
// TESTING
//  1. Reset mid-stream with id_valid=1 -> next cycle id_valid=0, bubble_cnt=0, if_ready=0 while reset=1.
//  2. Stream LUI,JAL,BRANCH,STORE,LOAD,SLLI(0x00311093),ADD, ex_ready=1 -> immsel 4,5,3,2,1,6,0 on consecutive cycles; bundle lags by 1.
//  3. LW x5 then ADD x6,x5,x1 -> one cycle with id_valid=0 between them, bubble_cnt=1; LW x0 then use x0 -> no bubble.
//  4. ex_ready=0 for 3 cycles with id_valid=1 -> if_ready=0 and outputs stable; resumes with no loss or duplicates.
//  5. flush with if_valid=1, id_valid=1 -> both dropped, id_valid=0 next cycle, bubble_cnt unchanged.
//  6. Opcode 0x7F -> id_illegal=1, immsel=0, regwen/memread/memwrite=0; CNT_W=2 forced 5 hazards -> bubble_cnt holds 3.

Source files
------------

// File: rtl/decode_ctrl_if.sv
// IF->ID->EX handshake and decoded bundle.
// master drives IF/EX inputs; slave is the decode stage.
interface decode_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            flush;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_valid;
  logic            ex_ready;
  logic [XLEN-1:0] id_pc;
  logic [24:0]     id_imm_bits;
  logic [3:0]      id_immsel;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [2:0]      id_funct3;
  logic            id_regwen;
  logic            id_memread;
  logic            id_memwrite;
  logic            id_alusrc;
  logic            id_branch;
  logic            id_jump;
  logic [1:0]      id_wbsel;
  logic            id_illegal;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output flush, if_valid, if_instr, if_pc, ex_ready,
    input  if_ready, id_valid, id_pc, id_imm_bits,
    input  id_immsel, id_rs1, id_rs2, id_rd, id_funct3,
    input  id_regwen, id_memread, id_memwrite,
    input  id_alusrc, id_branch, id_jump, id_wbsel,
    input  id_illegal, bubble_cnt
  );

  modport slave (
    input  flush, if_valid, if_instr, if_pc, ex_ready,
    output if_ready, id_valid, id_pc, id_imm_bits,
    output id_immsel, id_rs1, id_rs2, id_rd, id_funct3,
    output id_regwen, id_memread, id_memwrite,
    output id_alusrc, id_branch, id_jump, id_wbsel,
    output id_illegal, bubble_cnt
  );
endinterface

// File: rtl/decode_ctrl.sv
// Registered decode stage: IF instr -> EX control bundle.
// Ports: clk, reset (sync, high), bus (decode_ctrl_if.slave).
module decode_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  decode_ctrl_if.slave bus
);
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_OP   = 7'b0110011;

  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic [3:0] d_immsel;
  logic       d_regwen, d_memread, d_memwrite;
  logic       d_alusrc, d_branch, d_jump, d_illegal;
  logic [1:0] d_wbsel;
  logic       use1, use2;
  logic       hazard, accept;

  assign op  = bus.if_instr[6:0];
  assign f3  = bus.if_instr[14:12];
  assign rs1 = bus.if_instr[19:15];
  assign rs2 = bus.if_instr[24:20];
  assign rd  = bus.if_instr[11:7];

  always_comb begin
    d_immsel   = 4'd0;
    d_regwen   = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_alusrc   = 1'b0;
    d_branch   = 1'b0;
    d_jump     = 1'b0;
    d_wbsel    = 2'd0;
    d_illegal  = 1'b0;
    use1       = 1'b1;
    use2       = 1'b0;
    unique case (1'b1)
      (op == OP_LUI), (op == OP_AUI): begin
        d_immsel = 4'd4;
        d_regwen = 1'b1;
        d_alusrc = 1'b1;
        use1     = 1'b0;
      end
      (op == OP_JAL): begin
        d_immsel = 4'd5;
        d_jump   = 1'b1;
        d_wbsel  = 2'd2;
        d_regwen = 1'b1;
        use1     = 1'b0;
      end
      (op == OP_JALR): begin
        d_immsel = 4'd1;
        d_jump   = 1'b1;
        d_alusrc = 1'b1;
        d_wbsel  = 2'd2;
        d_regwen = 1'b1;
      end
      (op == OP_BR): begin
        d_immsel = 4'd3;
        d_branch = 1'b1;
        use2     = 1'b1;
      end
      (op == OP_LD): begin
        d_immsel  = 4'd1;
        d_memread = 1'b1;
        d_alusrc  = 1'b1;
        d_wbsel   = 2'd1;
        d_regwen  = 1'b1;
      end
      (op == OP_ST): begin
        d_immsel   = 4'd2;
        d_memwrite = 1'b1;
        d_alusrc   = 1'b1;
        use2       = 1'b1;
      end
      (op == OP_IMM): begin
        d_immsel = (f3 == 3'b001 || f3 == 3'b101)
                 ? 4'd6 : 4'd1;
        d_alusrc = 1'b1;
        d_regwen = 1'b1;
      end
      (op == OP_OP): begin
        d_regwen = 1'b1;
        use2     = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
    if (rd == 5'd0) d_regwen = 1'b0;
  end

  // Load in ID whose rd feeds the incoming instr: stall one cycle.
  assign hazard = bus.if_valid & bus.id_valid & bus.id_memread
                & (bus.id_rd != 5'd0)
                & ((use1 & (rs1 == bus.id_rd))
                 | (use2 & (rs2 == bus.id_rd)));

  assign bus.if_ready = ~reset & ~bus.flush & ~hazard
                      & (~bus.id_valid | bus.ex_ready);
  assign accept = bus.if_valid & bus.if_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.id_valid    <= 1'b0;
      bus.id_pc       <= '0;
      bus.id_imm_bits <= '0;
      bus.id_immsel   <= '0;
      bus.id_rs1      <= '0;
      bus.id_rs2      <= '0;
      bus.id_rd       <= '0;
      bus.id_funct3   <= '0;
      bus.id_regwen   <= 1'b0;
      bus.id_memread  <= 1'b0;
      bus.id_memwrite <= 1'b0;
      bus.id_alusrc   <= 1'b0;
      bus.id_branch   <= 1'b0;
      bus.id_jump     <= 1'b0;
      bus.id_wbsel    <= '0;
      bus.id_illegal  <= 1'b0;
      bus.bubble_cnt  <= '0;
    end else begin
      if (hazard && bus.ex_ready && !bus.flush
          && bus.bubble_cnt != '1)
        bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
      if (bus.flush) begin
        bus.id_valid <= 1'b0;
      end else if (accept) begin
        bus.id_valid    <= 1'b1;
        bus.id_pc       <= bus.if_pc;
        bus.id_imm_bits <= bus.if_instr[31:7];
        bus.id_immsel   <= d_immsel;
        bus.id_rs1      <= rs1;
        bus.id_rs2      <= rs2;
        bus.id_rd       <= rd;
        bus.id_funct3   <= f3;
        bus.id_regwen   <= d_regwen;
        bus.id_memread  <= d_memread;
        bus.id_memwrite <= d_memwrite;
        bus.id_alusrc   <= d_alusrc;
        bus.id_branch   <= d_branch;
        bus.id_jump     <= d_jump;
        bus.id_wbsel    <= d_wbsel;
        bus.id_illegal  <= d_illegal;
      end else if (bus.ex_ready) begin
        bus.id_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl.
// Second instance with CNT_W=2 checks counter saturation.
module tb_decode_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   vec = 0;
  int   err = 0;

  always #5 clk = ~clk;

  decode_ctrl_if #(.XLEN(32), .CNT_W(16)) b ();
  decode_ctrl_if #(.XLEN(32), .CNT_W(2))  b2 ();

  decode_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(b.slave)
  );
  decode_ctrl #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave)
  );

  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_LW3  = 32'h0000A183;
  localparam logic [31:0] I_SLLI = 32'h00311093;
  localparam logic [31:0] I_ADD  = 32'h00208233;
  localparam logic [31:0] I_LW5  = 32'h00002283;
  localparam logic [31:0] I_USE5 = 32'h00128333;
  localparam logic [31:0] I_LW0  = 32'h00002003;
  localparam logic [31:0] I_USE0 = 32'h00100333;
  localparam logic [31:0] I_A7   = 32'h00500393;
  localparam logic [31:0] I_A8   = 32'h00A00413;
  localparam logic [31:0] I_A9   = 32'h00100493;
  localparam logic [31:0] I_A10  = 32'h00100513;
  localparam logic [31:0] I_BAD  = 32'h00000FFF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc);
    b.if_valid = v;
    b.if_instr = ins;
    b.if_pc    = pc;
  endtask

  task automatic test_reset(input int exp_cnt_before);
    b.ex_ready = 1'b1;
    b.flush    = 1'b0;
    drive(1'b1, I_A7, 32'h40);
    step();
    vec++;
    if (b.id_valid !== 1'b1 || b.bubble_cnt !== 16'(exp_cnt_before)) begin
      err++;
      $display("FAIL rst_pre valid=%0b cnt=%0d exp 1/%0d",
               b.id_valid, b.bubble_cnt, exp_cnt_before);
    end
    reset = 1'b1;
    #1;
    vec++;
    if (b.if_ready !== 1'b0) begin
      err++;
      $display("FAIL rst_ifready got %0b exp 0", b.if_ready);
    end
    step();
    vec++;
    if (b.id_valid !== 1'b0 || b.bubble_cnt !== 16'd0 ||
        b.id_immsel !== 4'd0 || b.id_regwen !== 1'b0 ||
        b.id_rd !== 5'd0) begin
      err++;
      $display("FAIL rst_state valid=%0b cnt=%0d sel=%0d wen=%0b rd=%0d exp 0",
               b.id_valid, b.bubble_cnt, b.id_immsel, b.id_regwen, b.id_rd);
    end
    vec++;
    if (b.if_ready !== 1'b0 || b2.bubble_cnt !== 2'd0) begin
      err++;
      $display("FAIL rst_hold ifready=%0b cnt2=%0d exp 0/0",
               b.if_ready, b2.bubble_cnt);
    end
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_stream();
    logic [31:0] ins [7];
    logic [3:0]  sel [7];
    ins = '{I_LUI, I_JAL, I_BEQ, I_SW, I_LW3, I_SLLI, I_ADD};
    sel = '{4'd4, 4'd5, 4'd3, 4'd2, 4'd1, 4'd6, 4'd0};
    b.ex_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ins[i], 32'h100 + 32'(4 * i));
      #1;
      vec++;
      if (b.if_ready !== 1'b1) begin
        err++;
        $display("FAIL stream_rdy%0d got %0b exp 1", i, b.if_ready);
      end
      step();
      vec++;
      if (b.id_valid !== 1'b1 || b.id_immsel !== sel[i] ||
          b.id_pc !== 32'h100 + 32'(4 * i)) begin
        err++;
        $display("FAIL stream%0d valid=%0b sel=%0d pc=%h exp 1/%0d/%h",
                 i, b.id_valid, b.id_immsel, b.id_pc, sel[i],
                 32'h100 + 32'(4 * i));
      end
      if (i == 1) begin
        vec++;
        if (b.id_jump !== 1'b1 || b.id_wbsel !== 2'd2 ||
            b.id_regwen !== 1'b1) begin
          err++;
          $display("FAIL jal_ctrl jump=%0b wb=%0d wen=%0b exp 1/2/1",
                   b.id_jump, b.id_wbsel, b.id_regwen);
        end
      end
      if (i == 4) begin
        vec++;
        if (b.id_memread !== 1'b1 || b.id_wbsel !== 2'd1 ||
            b.id_alusrc !== 1'b1 || b.id_rd !== 5'd3) begin
          err++;
          $display("FAIL lw_ctrl mr=%0b wb=%0d as=%0b rd=%0d exp 1/1/1/3",
                   b.id_memread, b.id_wbsel, b.id_alusrc, b.id_rd);
        end
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_load_use();
    b.ex_ready = 1'b1;
    drive(1'b1, I_LW5, 32'h200);
    step();
    drive(1'b1, I_USE5, 32'h204);
    #1;
    vec++;
    if (b.if_ready !== 1'b0) begin
      err++;
      $display("FAIL hz_rdy got %0b exp 0", b.if_ready);
    end
    step();
    vec++;
    if (b.id_valid !== 1'b0 || b.bubble_cnt !== 16'd1) begin
      err++;
      $display("FAIL hz_bubble valid=%0b cnt=%0d exp 0/1",
               b.id_valid, b.bubble_cnt);
    end
    step();
    vec++;
    if (b.id_valid !== 1'b1 || b.id_rd !== 5'd6 ||
        b.id_pc !== 32'h204) begin
      err++;
      $display("FAIL hz_use valid=%0b rd=%0d pc=%h exp 1/6/204",
               b.id_valid, b.id_rd, b.id_pc);
    end
    drive(1'b1, I_LW0, 32'h300);
    step();
    drive(1'b1, I_USE0, 32'h304);
    #1;
    vec++;
    if (b.if_ready !== 1'b1) begin
      err++;
      $display("FAIL x0_rdy got %0b exp 1", b.if_ready);
    end
    step();
    vec++;
    if (b.id_valid !== 1'b1 || b.id_pc !== 32'h304 ||
        b.bubble_cnt !== 16'd1) begin
      err++;
      $display("FAIL x0_nobubble valid=%0b pc=%h cnt=%0d exp 1/304/1",
               b.id_valid, b.id_pc, b.bubble_cnt);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_stall();
    b.ex_ready = 1'b1;
    drive(1'b1, I_A7, 32'h400);
    step();
    b.ex_ready = 1'b0;
    drive(1'b1, I_A8, 32'h404);
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++;
      if (b.if_ready !== 1'b0) begin
        err++;
        $display("FAIL stall_rdy%0d got %0b exp 0", i, b.if_ready);
      end
      step();
      vec++;
      if (b.id_valid !== 1'b1 || b.id_rd !== 5'd7 ||
          b.id_pc !== 32'h400 || b.id_imm_bits !== I_A7[31:7]) begin
        err++;
        $display("FAIL stall_hold%0d valid=%0b rd=%0d pc=%h exp 1/7/400",
                 i, b.id_valid, b.id_rd, b.id_pc);
      end
    end
    b.ex_ready = 1'b1;
    #1;
    vec++;
    if (b.if_ready !== 1'b1) begin
      err++;
      $display("FAIL stall_resume_rdy got %0b exp 1", b.if_ready);
    end
    step();
    vec++;
    if (b.id_valid !== 1'b1 || b.id_rd !== 5'd8 ||
        b.id_pc !== 32'h404) begin
      err++;
      $display("FAIL stall_next valid=%0b rd=%0d pc=%h exp 1/8/404",
               b.id_valid, b.id_rd, b.id_pc);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    vec++;
    if (b.id_valid !== 1'b0) begin
      err++;
      $display("FAIL stall_drain valid=%0b exp 0", b.id_valid);
    end
  endtask

  task automatic test_flush();
    b.ex_ready = 1'b1;
    drive(1'b1, I_A9, 32'h500);
    step();
    b.ex_ready = 1'b0;
    b.flush    = 1'b1;
    drive(1'b1, I_A10, 32'h504);
    #1;
    vec++;
    if (b.if_ready !== 1'b0) begin
      err++;
      $display("FAIL flush_rdy got %0b exp 0", b.if_ready);
    end
    step();
    vec++;
    if (b.id_valid !== 1'b0 || b.bubble_cnt !== 16'd1) begin
      err++;
      $display("FAIL flush_kill valid=%0b cnt=%0d exp 0/1",
               b.id_valid, b.bubble_cnt);
    end
    b.flush    = 1'b0;
    b.ex_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    vec++;
    if (b.id_valid !== 1'b0) begin
      err++;
      $display("FAIL flush_after valid=%0b exp 0", b.id_valid);
    end
  endtask

  task automatic test_illegal();
    b.ex_ready = 1'b1;
    drive(1'b1, I_BAD, 32'h600);
    step();
    vec++;
    if (b.id_valid !== 1'b1 || b.id_illegal !== 1'b1 ||
        b.id_immsel !== 4'd0 || b.id_regwen !== 1'b0 ||
        b.id_memread !== 1'b0 || b.id_memwrite !== 1'b0 ||
        b.id_jump !== 1'b0 || b.id_branch !== 1'b0) begin
      err++;
      $display("FAIL illegal v=%0b ill=%0b sel=%0d wen=%0b mr=%0b mw=%0b exp 1/1/0/0/0/0",
               b.id_valid, b.id_illegal, b.id_immsel, b.id_regwen,
               b.id_memread, b.id_memwrite);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_saturate();
    int exp;
    b2.ex_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      b2.if_valid = 1'b1;
      b2.if_instr = I_LW5;
      step();
      b2.if_instr = I_USE5;
      step();
      step();
      exp = (k < 3) ? k : 3;
      vec++;
      if (b2.bubble_cnt !== 2'(exp) || b2.id_rd !== 5'd6) begin
        err++;
        $display("FAIL sat%0d cnt=%0d rd=%0d exp %0d/6",
                 k, b2.bubble_cnt, b2.id_rd, exp);
      end
    end
    b2.if_valid = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    b.flush = 1'b0;
    b.ex_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    b2.flush = 1'b0;
    b2.if_valid = 1'b0;
    b2.if_instr = 32'h0;
    b2.if_pc = 32'h0;
    b2.ex_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    test_reset(0);
    test_stream();
    test_load_use();
    test_stall();
    test_flush();
    test_illegal();
    test_saturate();
    test_reset(1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
